sub32_seq: RTL and testbench

Sequential 32-bit subtractor computing D = A − B − Bin one SLICE-bit ripple slice per clock, the inverse-direction companion to the 32-bit ripple-carry adder. It accepts a start pulse, runs a fixed-length multi-cycle operation, and signals completion with a one-cycle done pulse. The result is held, together with borrow, signed-overflow and zero flags, until the next operation completes. It sits beside the combinational adder in the arithmetic datapath wherever area matters more than latency.

---
 rtl/sub32_seq_if.sv | 64 ++++++
 rtl/sub32_seq.sv | 151 +++++++++++++++
 tb/tb_sub32_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sub32_seq_if.sv
// ---------------------------------------------------------------------------
// sub32_seq_if
//
// Purpose:
//   Groups the request and result signals of the sequential 32-bit
//   subtractor so the requester and the subtractor connect as one bundle.
//   Clock and reset are not part of the bundle; they stay plain ports.
//
// Signals:
//   start  requester -> subtractor  request, only looked at while idle
//   A      requester -> subtractor  32-bit minuend
//   B      requester -> subtractor  32-bit subtrahend
//   Bin    requester -> subtractor  borrow in (weight 1 at bit 0)
//   busy   subtractor -> requester  operation in progress
//   done   subtractor -> requester  one-cycle completion pulse
//   D      subtractor -> requester  registered difference
//   Bout   subtractor -> requester  borrow out (unsigned A < B + Bin)
//   V      subtractor -> requester  signed overflow
//   Z      subtractor -> requester  difference is zero
//
// Modports:
//   master  the requesting side (drives start/A/B/Bin)
//   slave   the subtractor itself (drives busy/done/D/flags)
// ---------------------------------------------------------------------------
interface sub32_seq_if;

    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        Bin;
    logic        busy;
    logic        done;
    logic [31:0] D;
    logic        Bout;
    logic        V;
    logic        Z;

    modport master (
        output start,
        output A,
        output B,
        output Bin,
        input  busy,
        input  done,
        input  D,
        input  Bout,
        input  V,
        input  Z
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        input  Bin,
        output busy,
        output done,
        output D,
        output Bout,
        output V,
        output Z
    );

endinterface

// File: rtl/sub32_seq.sv
// ---------------------------------------------------------------------------
// sub32_seq
//
// Purpose:
//   Sequential 32-bit subtractor computing D = A - B - Bin, one SLICE-bit
//   ripple slice per clock. The subtraction is done as A + ~B + ~Bin, so the
//   ripple carry starts at ~Bin and the final borrow is the inverted carry.
//   An operation takes N = 32/SLICE cycles in BUSY; completion is marked by
//   a one-cycle done pulse, and the result plus flags are held until the
//   next operation completes.
//
// Parameters:
//   SLICE  bits processed per cycle: 1, 2, 4, 8, 16 or 32
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    sub32_seq_if.slave: start/A/B/Bin in, busy/done/D/Bout/V/Z out
// ---------------------------------------------------------------------------
module sub32_seq #(
    parameter int SLICE = 4
) (
    input  logic         clk,
    input  logic         reset,
    sub32_seq_if.slave   bus
);

    localparam int N  = 32 / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [31:0]      a_q,     a_d;
    logic [31:0]      b_q,     b_d;
    logic             carry_q, carry_d;
    logic [31:0]      acc_q,   acc_d;
    logic [31:0]      d_q,     d_d;
    logic             bout_q,  bout_d;
    logic             v_q,     v_d;
    logic             z_q,     z_d;
    logic             done_q,  done_d;

    logic [4:0]       base;
    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE:0]   slice_sum;
    logic             last_slice;

    // Slice datapath: select the current SLICE bits of the latched operands
    // and add them with the inverted subtrahend and the running carry. The
    // top bit of slice_sum is the carry into the next slice.
    always_comb begin
        base       = 5'(cnt_q * SLICE);
        a_s        = a_q[base +: SLICE];
        b_s        = b_q[base +: SLICE];
        slice_sum  = {1'b0, a_s} + {1'b0, ~b_s} + (SLICE + 1)'(carry_q);
        last_slice = (cnt_q == CW'(N - 1));
    end

    // Next-state logic. Everything holds by default; done is a pulse and
    // therefore defaults low. The result registers are only loaded on the
    // final slice, so they keep the previous result throughout BUSY. The
    // overflow and zero flags look at the accumulator including the slice
    // written this cycle, which is exactly the value D is loaded with.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        d_d     = d_q;
        bout_d  = bout_q;
        v_d     = v_q;
        z_d     = z_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    carry_d = ~bus.Bin;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                acc_d[base +: SLICE] = slice_sum[SLICE-1:0];
                carry_d              = slice_sum[SLICE];
                cnt_d                = cnt_q + CW'(1);
                if (last_slice) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    d_d     = acc_d;
                    bout_d  = ~slice_sum[SLICE];
                    v_d     = (a_q[31] ^ b_q[31]) & (acc_d[31] ^ a_q[31]);
                    z_d     = (acc_d == 32'd0);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers. Reset clears everything, which also aborts an
    // operation in progress without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == BUSY);
    assign bus.done = done_q;
    assign bus.D    = d_q;
    assign bus.Bout = bout_q;
    assign bus.V    = v_q;
    assign bus.Z    = z_q;

endmodule

// File: tb/tb_sub32_seq.sv
// ---------------------------------------------------------------------------
// tb_sub32_seq
//
// Purpose:
//   Self-checking bench for sub32_seq with SLICE=4 (N=8). Directed cases
//   and randomized operations are compared against a reference model that
//   computes the difference and flags with plain wide integer arithmetic.
// ---------------------------------------------------------------------------
module tb_sub32_seq;

    localparam int SLICE = 4;
    localparam int N     = 32 / SLICE;

    logic clk;
    logic reset;

    int checks;
    int errors;

    logic [31:0] lastD;

    sub32_seq_if bus ();

    sub32_seq #(.SLICE(SLICE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: D, Bout, V, Z from 64-bit arithmetic on the operands.
    // Returns {Z, V, Bout, D}.
    function automatic logic [34:0] refModel(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic bin);
        longint unsigned ua;
        longint unsigned ub;
        longint          sd;
        logic [63:0]     ud;
        logic            bout;
        logic            v;
        logic [31:0]     d;
        ua   = 64'(a);
        ub   = 64'(b);
        ud   = ua - ub - 64'(bin);
        d    = ud[31:0];
        bout = (ua < ub + 64'(bin));
        sd   = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        v    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        return {(d == 32'd0), v, bout, d};
    endfunction

    // Drive a request at the current negedge; it is sampled on the next
    // posedge, after which start is dropped.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic bin);
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Full operation: start, watch the BUSY window, then check the done
    // cycle against the model. With disturb set, a second start with other
    // operands is pulsed mid-operation and A keeps changing; both must be
    // ignored. Returns at the negedge inside the done cycle.
    task automatic runOp(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic bin,
                         input bit disturb);
        logic [34:0] exp;
        int          busyCycles;
        logic        earlyDone;
        logic        held;
        exp        = refModel(a, b, bin);
        busyCycles = 0;
        earlyDone  = 1'b0;
        held       = 1'b1;
        applyStimulus(a, b, bin);
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            if (bus.busy) busyCycles++;
            if (bus.done) earlyDone = 1'b1;
            if (bus.D !== lastD) held = 1'b0;
            if (disturb && c < N - 1) begin
                bus.start = (c == 2);
                bus.A     = (c == 2) ? 32'd1 : $urandom;
                bus.B     = (c == 2) ? 32'd1 : bus.B;
                bus.Bin   = (c == 2) ? 1'b1 : bus.Bin;
            end
        end
        bus.start = 1'b0;
        checkOutput({tag, " busyCycles"}, 32'(busyCycles), 32'(N));
        checkOutput({tag, " noEarlyDone"}, 32'(earlyDone), 32'd0);
        checkOutput({tag, " dHeld"}, 32'(held), 32'd1);
        @(negedge clk);
        checkOutput({tag, " done"}, 32'(bus.done), 32'd1);
        checkOutput({tag, " busyLow"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " D"}, bus.D, exp[31:0]);
        checkOutput({tag, " Bout"}, 32'(bus.Bout), 32'(exp[32]));
        checkOutput({tag, " V"}, 32'(bus.V), 32'(exp[33]));
        checkOutput({tag, " Z"}, 32'(bus.Z), 32'(exp[34]));
        lastD = exp[31:0];
    endtask

    // All outputs must read as their reset values.
    task automatic checkCleared(input string tag);
        checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, " D"}, bus.D, 32'd0);
        checkOutput({tag, " Bout"}, 32'(bus.Bout), 32'd0);
        checkOutput({tag, " V"}, 32'(bus.V), 32'd0);
        checkOutput({tag, " Z"}, 32'(bus.Z), 32'd0);
    endtask

    initial begin
        logic sawDone;
        logic sawBusy;
        checks    = 0;
        errors    = 0;
        lastD     = 32'd0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        bus.Bin   = 1'b0;

        repeat (2) @(negedge clk);
        checkCleared("reset");
        reset = 1'b0;
        @(negedge clk);

        // Directed cases from the basic arithmetic and flag corners.
        runOp("5-3",        32'd5,          32'd3,          1'b0, 1'b0);
        runOp("3-5",        32'd3,          32'd5,          1'b0, 1'b0);
        runOp("bin1",       32'h12345678,   32'h02345678,   1'b1, 1'b0);
        runOp("zero",       32'd2,          32'd1,          1'b1, 1'b0);
        runOp("0-0-1",      32'd0,          32'd0,          1'b1, 1'b0);
        runOp("negOvf",     32'h80000000,   32'd1,          1'b0, 1'b0);
        runOp("posOvf",     32'h7FFFFFFF,   32'hFFFFFFFF,   1'b0, 1'b0);

        // Ignored mid-operation start and operand changes, then a request
        // in the done cycle that must be accepted back-to-back.
        runOp("10-4 dist",  32'd10,         32'd4,          1'b0, 1'b1);
        runOp("9-9 b2b",    32'd9,          32'd9,          1'b0, 1'b0);

        // Reset in the middle of an operation.
        runOp("pre-rst",    32'd5,          32'd3,          1'b0, 1'b0);
        applyStimulus(32'd100, 32'd1, 1'b0);
        repeat (4) @(negedge clk);
        #1 reset = 1'b1;
        #1 checkCleared("midReset");
        #1 reset = 1'b0;
        lastD   = 32'd0;
        sawDone = 1'b0;
        sawBusy = 1'b0;
        for (int c = 0; c < N + 2; c++) begin
            @(negedge clk);
            if (bus.done) sawDone = 1'b1;
            if (bus.busy) sawBusy = 1'b1;
        end
        checkOutput("abort noDone", 32'(sawDone), 32'd0);
        checkOutput("abort noBusy", 32'(sawBusy), 32'd0);
        runOp("7-2 after",  32'd7,          32'd2,          1'b0, 1'b0);

        // Randomized operations, some back-to-back, some with disturbance,
        // some separated by idle gaps.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) ra = {1'b1, ra[30:0]};
            runOp($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                checkOutput($sformatf("rand%0d idleHold", i), bus.D, lastD);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
